sha256_block_sequencer: RTL and testbench

- Sequences the SHA-256 compression core behind the hasher's AXI4-Lite register front end.
- Accepts a pre-padded message as a 32-bit word stream and assembles 16-word (512-bit) blocks.
- Issues init/next commands to the core, waits for each block to complete, then streams the 256-bit digest out as eight 32-bit words.
- Also provides a core watchdog, an abort path, and status/error reporting for the register file.

---
 rtl/sha256_block_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_sha256_block_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_sequencer.sv
// Packs a pre-padded 32-bit message stream into 512-bit blocks, drives init/next on the
// SHA-256 core, watches for a hung core and streams the final digest out word by word.
module sha256_block_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int BLK_CNT_W      = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [31:0]          m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic [511:0]         core_block,
    output logic                 core_init,
    output logic                 core_next,
    input  logic                 core_ready,
    input  logic [255:0]         core_digest,
    input  logic                 core_digest_valid,
    input  logic                 abort,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [BLK_CNT_W-1:0] blk_cnt
);
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic [511:0]         block_q, block_d;
    logic [255:0]         digest_q, digest_d;
    logic [2:0]           k_q, k_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 s_ready_q, s_ready_d;
    logic                 m_valid_q, m_valid_d;
    logic                 done_q, done_d;

    logic              s_hs, m_hs, issue_fire, complete, wr_word;
    logic [WDOG_W-1:0] wdog_inc;
    logic [31:0]       dig_word [8];

    assign s_hs       = s_valid & s_ready_q;
    assign m_hs       = m_valid_q & m_ready;
    assign issue_fire = (state_q == ST_ISSUE) & core_ready & ~abort;
    assign wdog_inc   = wdog_q + WDOG_W'(1);
    // The first WAIT cycle can still see the core's pre-command ready/valid, so skip it.
    assign complete   = (wdog_q != '0) & core_ready & core_digest_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dig
            assign dig_word[gi] = digest_q[255-32*gi -: 32];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        first_d    = first_q;
        last_d     = last_q;
        wdog_d     = wdog_q;
        block_d    = block_q;
        digest_d   = digest_q;
        k_d        = k_q;
        blk_cnt_d  = blk_cnt_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        wr_word    = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            first_d    = 1'b1;
            wdog_d     = '0;
            k_d        = '0;
            err_code_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_hs) begin
                        blk_cnt_d  = '0;
                        err_code_d = 2'd0;
                        first_d    = 1'b1;
                        if (s_last) begin
                            state_d    = ST_ERROR;
                            err_code_d = 2'd1;
                        end else begin
                            wr_word = 1'b1;
                            idx_d   = 4'd1;
                            state_d = ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (s_hs) begin
                        if (s_last && (idx_q != 4'd15)) begin
                            state_d    = ST_ERROR;
                            err_code_d = 2'd1;
                        end else begin
                            wr_word = 1'b1;
                            idx_d   = idx_q + 4'd1;
                            if (idx_q == 4'd15) begin
                                last_d  = s_last;
                                state_d = ST_ISSUE;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (core_ready) begin
                        first_d = 1'b0;
                        wdog_d  = '0;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wdog_d = wdog_inc;
                    if (complete) begin
                        if (~&blk_cnt_q) begin
                            blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
                        end
                        if (last_q) begin
                            digest_d = core_digest;
                            k_d      = '0;
                            state_d  = ST_DRAIN;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else if (wdog_inc == WDOG_W'(TIMEOUT_CYCLES)) begin
                        state_d    = ST_ERROR;
                        err_code_d = 2'd2;
                    end
                end
                ST_DRAIN: begin
                    if (m_hs) begin
                        k_d = k_q + 3'd1;
                        if (k_q == 3'd7) begin
                            done_d  = 1'b1;
                            first_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ERROR: begin
                    if (err_clr) begin
                        state_d    = ST_IDLE;
                        err_code_d = 2'd0;
                        idx_d      = '0;
                        first_d    = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (wr_word) begin
            for (int i = 0; i < 16; i++) begin
                if (idx_q == 4'(i)) begin
                    block_d[511-32*i -: 32] = s_data;
                end
            end
        end

        // Registered handshake outputs follow the next state so they are clean after reset.
        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
        m_valid_d = (state_d == ST_DRAIN);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            wdog_q     <= '0;
            block_q    <= '0;
            digest_q   <= '0;
            k_q        <= '0;
            blk_cnt_q  <= '0;
            err_code_q <= 2'd0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            first_q    <= first_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            block_q    <= block_d;
            digest_q   <= digest_d;
            k_q        <= k_d;
            blk_cnt_q  <= blk_cnt_d;
            err_code_q <= err_code_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            done_q     <= done_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = m_valid_q;
    assign m_data     = dig_word[k_q];
    assign m_last     = m_valid_q & (k_q == 3'd7);
    assign core_block = block_q;
    assign core_init  = issue_fire & first_q;
    assign core_next  = issue_fire & ~first_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = (state_q == ST_ERROR);
    assign err_code   = err_code_q;
    assign blk_cnt    = blk_cnt_q;
    assign done       = done_q;
endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: a behavioural SHA-256 core answers init/next, and
// digests are predicted by folding a plain SHA-256 compression over the message blocks.
module tb_sha256_block_sequencer;
    localparam int TB_TIMEOUT = 100;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, abort = 1'b0, err_clr = 1'b0;
    logic         s_ready, m_valid, m_last, core_init, core_next, busy, done, err;
    logic [31:0]  m_data;
    logic [511:0] core_block;
    logic [1:0]   err_code;
    logic [15:0]  blk_cnt;

    logic         core_ready = 1'b1, core_digest_valid = 1'b0, pending = 1'b0, hang = 1'b0;
    logic [255:0] core_digest = '0, model_h = '0;
    int           lat = 0, n_init = 0, n_next = 0;

    int compared = 0, mismatched = 0, exp_inits = 0, exp_nexts = 0;

    always #5 ACLK = ~ACLK;

    sha256_block_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT), .BLK_CNT_W(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .core_block(core_block), .core_init(core_init), .core_next(core_next),
        .core_ready(core_ready), .core_digest(core_digest), .core_digest_valid(core_digest_valid),
        .abort(abort), .err_clr(err_clr), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .blk_cnt(blk_cnt)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + h[255:224], b + h[223:192], c + h[191:160], d + h[159:128],
                e + h[127:96],  f + h[95:64],   g + h[63:32],   hh + h[31:0]};
    endfunction

    // Behavioural core: busy for a random few cycles per command; 'hang' freezes it.
    always @(posedge ACLK) begin
        if (core_init || core_next) begin
            if (core_init) begin
                n_init  <= n_init + 1;
                model_h <= compress(IV, core_block);
            end else begin
                n_next  <= n_next + 1;
                model_h <= compress(model_h, core_block);
            end
            core_ready        <= 1'b0;
            core_digest_valid <= 1'b0;
            pending           <= 1'b1;
            lat               <= int'($urandom_range(0, 5));
        end else if (pending && !hang) begin
            if (lat == 0) begin
                core_ready        <= 1'b1;
                core_digest_valid <= 1'b1;
                core_digest       <= model_h;
                pending           <= 1'b0;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int cnt = 0;
        s_data = d; s_last = l; s_valid = 1'b1;
        while (!s_ready && cnt < 200) begin
            @(negedge ACLK);
            cnt++;
        end
        chk("s_ready_wait", s_ready, 1);
        @(negedge ACLK);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_block(input logic [511:0] blk, input logic last, input logic exp_init, input string tag);
        for (int i = 0; i < 16; i++) send_word(blk[511-32*i -: 32], last && (i == 15));
        chk({tag, " core_init"}, core_init, exp_init);
        chk({tag, " core_next"}, core_next, !exp_init);
        chk({tag, " s_ready_after_block"}, s_ready, 0);
        if (exp_init) exp_inits++; else exp_nexts++;
    endtask

    task automatic recv(input logic [255:0] exp, input int mode, input string tag);
        int k = 0;
        int cyc = 0;
        logic tog = 1'b0;
        while (k < 8 && cyc < 400) begin
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            if (m_valid) begin
                chk($sformatf("%s word%0d", tag, k), m_data, exp[255-32*k -: 32]);
                chk($sformatf("%s m_last%0d", tag, k), m_last, (k == 7));
            end
            if (m_valid && m_ready) k++;
            @(negedge ACLK);
            cyc++;
        end
        m_ready = 1'b0;
        chk({tag, " words_received"}, k, 8);
        chk({tag, " done"}, done, 1);
        chk({tag, " m_valid_after"}, m_valid, 0);
        chk({tag, " busy_after"}, busy, 0);
        $display("msg %s: digest %h, blk_cnt %0d", tag, exp, blk_cnt);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        logic [511:0] abc_blk, two1, two2, rb;
        logic [511:0] msg [4];
        logic [255:0] h;
        int nb, cnt;

        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0] = 32'h00000018;
        two1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two2 = {480'h0, 32'h000001c0};

        // Reset values
        repeat (3) @(negedge ACLK);
        chk("rst s_ready", s_ready, 0);
        chk("rst m_valid", m_valid, 0);
        chk("rst m_data", m_data, 0);
        chk("rst m_last", m_last, 0);
        chk("rst core_init", core_init, 0);
        chk("rst core_next", core_next, 0);
        chk("rst core_block", core_block, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst err_code", err_code, 0);
        chk("rst blk_cnt", blk_cnt, 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("idle s_ready", s_ready, 1);

        // One-block "abc"
        send_block(abc_blk, 1'b1, 1'b1, "abc");
        recv(ABC_DIG, 0, "abc");
        chk("abc blk_cnt", blk_cnt, 1);

        // Two-block message
        send_block(two1, 1'b0, 1'b1, "two_b0");
        send_block(two2, 1'b1, 1'b0, "two_b1");
        recv(TWO_DIG, 0, "two");
        chk("two blk_cnt", blk_cnt, 2);

        // Random multi-block messages; mode 1 toggles m_ready every cycle
        for (int m = 0; m < 3; m++) begin
            nb = int'($urandom_range(1, 3));
            h = IV;
            for (int b = 0; b < nb; b++) begin
                for (int w = 0; w < 16; w++) msg[b][511-32*w -: 32] = $urandom;
                h = compress(h, msg[b]);
            end
            for (int b = 0; b < nb; b++)
                send_block(msg[b], (b == nb - 1), (b == 0), $sformatf("rnd%0d_b%0d", m, b));
            recv(h, (m == 0) ? 1 : 2, $sformatf("rnd%0d", m));
            chk($sformatf("rnd%0d blk_cnt", m), blk_cnt, nb);
        end

        // Early s_last on word 5
        for (int w = 0; w < 5; w++) send_word($urandom, 1'b0);
        send_word($urandom, 1'b1);
        chk("early err", err, 1);
        chk("early err_code", err_code, 1);
        chk("early s_ready", s_ready, 0);
        chk("early busy", busy, 1);
        chk("early core_init", core_init, 0);
        chk("early blk_cnt", blk_cnt, 0);
        repeat (3) @(negedge ACLK);
        chk("early no_pulse", n_init, exp_inits);
        err_clr = 1'b1;
        @(negedge ACLK);
        err_clr = 1'b0;
        chk("errclr err", err, 0);
        chk("errclr err_code", err_code, 0);
        chk("errclr busy", busy, 0);
        chk("errclr s_ready", s_ready, 1);
        $display("msg early_last: error reported and cleared");

        // Core hang -> watchdog timeout
        hang = 1'b1;
        for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom;
        send_block(rb, 1'b1, 1'b1, "hang");
        cnt = 0;
        while (!err && cnt < TB_TIMEOUT + 20) begin
            @(negedge ACLK);
            cnt++;
        end
        chk("timeout cycles", cnt, TB_TIMEOUT + 1);
        chk("timeout err_code", err_code, 2);
        chk("timeout blk_cnt", blk_cnt, 0);
        err_clr = 1'b1;
        @(negedge ACLK);
        err_clr = 1'b0;
        hang = 1'b0;
        repeat (10) @(negedge ACLK);
        chk("timeout cleared", err_code, 0);
        $display("msg timeout: err_code 2 after %0d cycles", cnt);

        // Abort at word 9 of the second block, then a clean "abc"
        for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom;
        send_block(rb, 1'b0, 1'b1, "abort_b0");
        for (int w = 0; w < 9; w++) send_word($urandom, 1'b0);
        s_data = $urandom; s_valid = 1'b1; abort = 1'b1;
        @(negedge ACLK);
        s_valid = 1'b0; abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort s_ready", s_ready, 1);
        chk("abort err_code", err_code, 0);
        chk("abort blk_cnt", blk_cnt, 1);
        chk("abort m_valid", m_valid, 0);
        chk("abort no_next", n_next, exp_nexts);
        send_block(abc_blk, 1'b1, 1'b1, "post_abort");
        recv(ABC_DIG, 2, "post_abort");
        chk("post_abort blk_cnt", blk_cnt, 1);

        // Asynchronous reset while the core is busy
        hang = 1'b1;
        for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom;
        send_block(rb, 1'b1, 1'b1, "midrst");
        repeat (3) @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst s_ready", s_ready, 0);
        chk("midrst core_init", core_init, 0);
        chk("midrst core_next", core_next, 0);
        chk("midrst core_block", core_block, 0);
        chk("midrst blk_cnt", blk_cnt, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        hang = 1'b0;
        repeat (10) @(negedge ACLK);
        chk("total core_init pulses", n_init, exp_inits);
        chk("total core_next pulses", n_next, exp_nexts);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
